el2_exu_div_noc_ctrl: RTL and testbench
=======================================

Name: el2_exu_div_noc_ctrl

Overview:
Sequencer for the NoC-attached divider. It accepts one divide request from decode, serialises the operands to the divider through the NoC sender, and waits for the result from the NoC receiver. It returns the result to the EXU with a one-cycle finish pulse. It also handles cancel/flush, including draining a stale in-flight result, and resolves divide-by-zero locally without a NoC round trip.

Parameters:
DATA_W, 32, operand/result width
PKT_W, 66, request packet width = 2*DATA_W+2
TIMEOUT_CYCLES, 1024, WAIT/DRAIN limit (used only with optional feature)

Ports:
clk_noc  in  1  NoC clock (single clock)
rst_l  in  1  reset, asynchronous, active-low
dec_div_valid  in  1  divide request
dec_div_unsigned  in  1  unsigned op
dec_div_rem  in  1  remainder (vs quotient)
dividend  in  32  operand A
divisor  in  32  operand B
dec_div_cancel  in  1  kill current divide
div_busy  out  1  controller not IDLE
tx_valid  out  1  request packet valid to NoC sender
tx_ready  in  1  sender accepts packet
tx_packet  out  66  {rem, unsigned, dividend, divisor}
rx_valid  in  1  result packet from NoC receiver
rx_packet  in  32  result
noc_sr_flush  out  1  one-cycle pulse: receiver may accept new data
finish_dly  out  1  one-cycle result-valid pulse
out  out  32  result, held until next finish_dly
div_error  out  1  timeout pulse (optional feature)

Behaviour:
- Reset (rst_l=0, async): state=IDLE; div_busy, tx_valid, noc_sr_flush, finish_dly, div_error = 0; out=0; tx_packet=0; timeout counter=0.
- States: IDLE, SEND, WAIT, DRAIN, ZERO.
- IDLE:
  - dec_div_valid & ~dec_div_cancel & divisor!=0 -> latch operands/op into tx_packet, go SEND.
  - divisor==0 -> go ZERO.
  - dec_div_cancel has priority: request dropped, stay IDLE.
- ZERO: next cycle finish_dly=1; out=32'hFFFF_FFFF (quotient) or latched dividend (rem), signed and unsigned alike. Go IDLE. Cancel while in ZERO: no finish_dly, go IDLE.
- SEND: tx_valid=1, tx_packet stable until handshake.
  - tx_valid & tx_ready -> WAIT.
  - Cancel without tx_ready -> drop tx_valid next cycle, go IDLE; nothing enters the NoC.
  - Cancel together with tx_ready -> packet counts as sent, go DRAIN.
- WAIT:
  - rx_valid -> next cycle finish_dly=1, out=rx_packet, noc_sr_flush=1, go IDLE.
  - Cancel -> DRAIN. Cancel and rx_valid in the same cycle -> result discarded, noc_sr_flush=1, go IDLE, no finish_dly.
- DRAIN: wait for rx_valid; discard the result, pulse noc_sr_flush, go IDLE. Never asserts finish_dly.
- Latency: request to tx_valid = 1 cycle; rx_valid to finish_dly = 1 cycle; div-by-zero request to finish_dly = 2 cycles.
- div_busy = (state != IDLE). Decode must not raise dec_div_valid while div_busy; such requests are ignored.
- rx_valid outside WAIT/DRAIN: ignored, no output change.
- A new request may be accepted in the cycle after finish_dly (back-to-back).

Optional Feature:
- Macro EL2_DIV_NOC_TIMEOUT_EN.
- Enabled:
  - A counter clears on entry to WAIT/DRAIN and increments each cycle in those states.
  - On reaching TIMEOUT_CYCLES-1 without rx_valid: div_error and noc_sr_flush pulse for one cycle, go IDLE, no finish_dly.
  - Counter saturates; it never wraps.
- Disabled: no counter logic; WAIT/DRAIN wait indefinitely; div_error tied 0.

Test Plan:
- Signed 100/7 quotient, tx_ready=1, rx_valid with 14 three cycles after handshake -> tx_packet={0,0,100,7}; finish_dly pulses exactly once, one cycle after rx_valid; out=14; noc_sr_flush pulse; div_busy low afterwards.
- Divisor=0, dividend=0x1234, rem=1 -> no tx_valid; finish_dly two cycles after request; out=0x1234. Repeat with rem=0 -> out=0xFFFF_FFFF.
- tx_ready held low 5 cycles -> tx_valid and tx_packet stable throughout. Cancel in cycle 3 -> tx_valid drops next cycle, state IDLE, no finish_dly.
- Cancel in WAIT, then rx_valid with 0xDEAD two cycles later -> no finish_dly; out keeps previous value; noc_sr_flush pulses once. A new request immediately afterwards completes normally.
- Assert rst_l=0 mid-WAIT -> all outputs 0 asynchronously. rx_valid after reset release is ignored.
- With EL2_DIV_NOC_TIMEOUT_EN and TIMEOUT_CYCLES=16, no rx_valid -> div_error pulse 16 cycles after entering WAIT; state returns to IDLE.

Source files
------------

// File: rtl/el2_exu_div_noc_ctrl.sv
// el2_exu_div_noc_ctrl: sequences one divide through the NoC divider, resolves divide-by-zero locally.
// Define EL2_DIV_NOC_TIMEOUT_EN to abort WAIT/DRAIN after TIMEOUT_CYCLES with a div_error pulse.
module el2_exu_div_noc_ctrl #(
  parameter int DATA_W         = 32,
  parameter int PKT_W          = 2*DATA_W+2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_noc,
  input  logic              rst_l,
  input  logic              dec_div_valid,
  input  logic              dec_div_unsigned,
  input  logic              dec_div_rem,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              dec_div_cancel,
  output logic              div_busy,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [PKT_W-1:0]  tx_packet,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_packet,
  output logic              noc_sr_flush,
  output logic              finish_dly,
  output logic [DATA_W-1:0] out,
  output logic              div_error
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEND  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_ZERO  = 3'd4;
  logic [2:0]        r_state, w_next;
  logic [PKT_W-1:0]  r_packet;
  logic [DATA_W-1:0] r_out;
  logic              r_finish, r_flush, r_error;
  logic              w_accept, w_wd, w_fin_zero, w_fin_rx, w_timeout;
  assign w_accept   = (r_state == S_IDLE) & dec_div_valid & ~dec_div_cancel;
  assign w_wd       = (r_state == S_WAIT) | (r_state == S_DRAIN);
  assign w_fin_zero = (r_state == S_ZERO) & ~dec_div_cancel;
  assign w_fin_rx   = (r_state == S_WAIT) & rx_valid & ~dec_div_cancel;
`ifdef EL2_DIV_NOC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] r_cnt;
  assign w_timeout = w_wd & ~rx_valid & (r_cnt == LAST);
  // restart on every entry into WAIT or DRAIN, including WAIT->DRAIN
  always_ff @(posedge clk_noc or negedge rst_l) begin
    if (!rst_l) r_cnt <= '0;
    else if (((w_next == S_WAIT) | (w_next == S_DRAIN)) & (w_next != r_state)) r_cnt <= '0;
    else if (w_wd & (r_cnt != LAST)) r_cnt <= r_cnt + 1'b1;
  end
`else
  assign w_timeout = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (divisor == '0) ? S_ZERO : S_SEND;
      S_SEND:  w_next = tx_ready ? (dec_div_cancel ? S_DRAIN : S_WAIT) : (dec_div_cancel ? S_IDLE : S_SEND);
      S_WAIT:  w_next = (rx_valid | w_timeout) ? S_IDLE : (dec_div_cancel ? S_DRAIN : S_WAIT);
      S_DRAIN: w_next = (rx_valid | w_timeout) ? S_IDLE : S_DRAIN;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_noc or negedge rst_l) begin
    if (!rst_l) begin
      r_state  <= S_IDLE;
      r_packet <= '0;
      r_out    <= '0;
      r_finish <= 1'b0;
      r_flush  <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_finish <= w_fin_zero | w_fin_rx;
      r_flush  <= (w_wd & rx_valid) | w_timeout;
      r_error  <= w_timeout;
      if (w_accept) r_packet <= {dec_div_rem, dec_div_unsigned, dividend, divisor};
      if (w_fin_zero) r_out <= r_packet[PKT_W-1] ? r_packet[2*DATA_W-1:DATA_W] : '1;
      else if (w_fin_rx) r_out <= rx_packet;
    end
  end
  assign div_busy     = (r_state != S_IDLE);
  assign tx_valid     = (r_state == S_SEND);
  assign tx_packet    = r_packet;
  assign noc_sr_flush = r_flush;
  assign finish_dly   = r_finish;
  assign out          = r_out;
  assign div_error    = r_error;
endmodule

// File: tb/tb_el2_exu_div_noc_ctrl.sv
// tb_el2_exu_div_noc_ctrl: transaction-level randomized bench with a spec-rule reference model.
module tb_el2_exu_div_noc_ctrl;
  logic        clk_noc = 1'b0, rst_l = 1'b0;
  logic        dec_div_valid = 0, dec_div_unsigned = 0, dec_div_rem = 0, dec_div_cancel = 0;
  logic [31:0] dividend = 0, divisor = 0, rx_packet = 0;
  logic        tx_ready = 0, rx_valid = 0;
  logic        div_busy, tx_valid, noc_sr_flush, finish_dly, div_error;
  logic [65:0] tx_packet;
  logic [31:0] out;
  int          n_cmp = 0, n_bad = 0, n_fin = 0, n_flush = 0;
  logic [31:0] exp_out = 0;
  always #5 clk_noc = ~clk_noc;
  el2_exu_div_noc_ctrl #(.DATA_W(32), .PKT_W(66), .TIMEOUT_CYCLES(16)) dut (
    .clk_noc(clk_noc), .rst_l(rst_l), .dec_div_valid(dec_div_valid),
    .dec_div_unsigned(dec_div_unsigned), .dec_div_rem(dec_div_rem),
    .dividend(dividend), .divisor(divisor), .dec_div_cancel(dec_div_cancel),
    .div_busy(div_busy), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_packet(tx_packet),
    .rx_valid(rx_valid), .rx_packet(rx_packet), .noc_sr_flush(noc_sr_flush),
    .finish_dly(finish_dly), .out(out), .div_error(div_error)
  );
  always @(posedge clk_noc) #1 begin
    if (finish_dly) n_fin++;
    if (noc_sr_flush) n_flush++;
  end
  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(negedge clk_noc);
  endtask
  // kind: 0 normal, 1 div-by-zero, 2 cancel in SEND, 3 cancel with tx_ready,
  // 4 cancel in WAIT, 5 cancel with rx_valid, 6 cancel with request, 7 cancel in ZERO
  task automatic txn(input int kind, input logic [31:0] a, input logic [31:0] b, input logic rm,
                     input logic us, input logic [31:0] rd, input int dr, input int lat, input int cc);
    int f0, l0;
    logic fin_exp, flush_exp;
    f0 = n_fin; l0 = n_flush; fin_exp = 0; flush_exp = 0;
    dec_div_valid = 1; dividend = a; divisor = b; dec_div_rem = rm; dec_div_unsigned = us;
    dec_div_cancel = (kind == 6);
    step;
    dec_div_valid = 0; dec_div_cancel = 0; dividend = $urandom; divisor = $urandom;
    if (kind == 6) begin
      chk("drop_busy", div_busy, 0);
      chk("drop_txv", tx_valid, 0);
    end else if (kind == 1 || kind == 7) begin
      chk("zero_txv", tx_valid, 0);
      chk("zero_busy", div_busy, 1);
      dec_div_cancel = (kind == 7);
      step;
      dec_div_cancel = 0;
      if (kind == 1) begin fin_exp = 1; exp_out = rm ? a : 32'hFFFF_FFFF; end
      chk("zero_fin", finish_dly, fin_exp);
      chk("zero_out", out, exp_out);
      chk("zero_txv2", tx_valid, 0);
    end else begin
      chk("txv", tx_valid, 1);
      chk("pkt", tx_packet, {rm, us, a, b});
      for (int i = 0; i < dr; i++) begin
        step;
        chk("txv_hold", tx_valid, 1);
        chk("pkt_hold", tx_packet, {rm, us, a, b});
      end
      if (kind == 2) begin
        dec_div_cancel = 1;
        step;
        dec_div_cancel = 0;
        chk("cxl_txv", tx_valid, 0);
        chk("cxl_busy", div_busy, 0);
      end else begin
        tx_ready = 1; dec_div_cancel = (kind == 3);
        step;
        tx_ready = 0; dec_div_cancel = 0;
        chk("wait_txv", tx_valid, 0);
        chk("wait_busy", div_busy, 1);
        for (int i = 0; i < lat; i++) begin
          dec_div_cancel = (kind == 4 && i == cc);
          step;
        end
        dec_div_cancel = (kind == 5);
        rx_valid = 1; rx_packet = rd;
        step;
        rx_valid = 0; dec_div_cancel = 0; rx_packet = $urandom;
        flush_exp = 1;
        if (kind == 0) begin fin_exp = 1; exp_out = rd; end
        chk("rx_fin", finish_dly, fin_exp);
        chk("rx_flush", noc_sr_flush, 1);
        chk("rx_out", out, exp_out);
        chk("rx_busy", div_busy, 0);
      end
    end
    step;
    step;
    chk("fin_cnt", 66'(n_fin - f0), 66'(fin_exp));
    chk("flush_cnt", 66'(n_flush - l0), 66'(flush_exp));
    chk("idle_busy", div_busy, 0);
    chk("idle_out", out, exp_out);
    chk("idle_err", div_error, 0);
  endtask
  task automatic stray_rx;
    rx_valid = 1; rx_packet = $urandom;
    step;
    rx_valid = 0;
    chk("stray_fin", finish_dly, 0);
    chk("stray_flush", noc_sr_flush, 0);
    chk("stray_out", out, exp_out);
  endtask
  initial begin
    int kind, lat;
    logic [31:0] b;
    step;
    chk("rst_busy", div_busy, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_fin", finish_dly, 0);
    chk("rst_flush", noc_sr_flush, 0);
    chk("rst_out", out, 0);
    chk("rst_pkt", tx_packet, 0);
    chk("rst_err", div_error, 0);
    rst_l = 1;
    step;
    txn(0, 100, 7, 0, 0, 14, 0, 3, 0);
    txn(1, 32'h1234, 0, 1, 0, 0, 0, 1, 0);
    txn(1, 32'h1234, 0, 0, 1, 0, 0, 1, 0);
    txn(2, 55, 3, 0, 0, 0, 3, 1, 0);
    txn(4, 77, 9, 1, 1, 32'hDEAD, 0, 2, 0);
    txn(0, 81, 9, 0, 1, 9, 0, 1, 0);
    stray_rx;
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 7);
      b = $urandom;
      if (kind == 1 || kind == 7) b = 0;
      else if (b == 0) b = 1;
      lat = $urandom_range(1, 5);
      txn(kind, $urandom, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
          $urandom_range(0, 4), lat, $urandom_range(0, lat - 1));
      if ($urandom_range(0, 3) == 0) stray_rx;
    end
    dec_div_valid = 1; dividend = 50; divisor = 5;
    step;
    dec_div_valid = 0; tx_ready = 1;
    step;
    tx_ready = 0;
    step;
    #2 rst_l = 0;
    #1;
    exp_out = 0;
    chk("arst_busy", div_busy, 0);
    chk("arst_txv", tx_valid, 0);
    chk("arst_fin", finish_dly, 0);
    chk("arst_out", out, 0);
    chk("arst_pkt", tx_packet, 0);
    step;
    rst_l = 1;
    step;
    stray_rx;
    chk("arst_idle", div_busy, 0);
    dec_div_valid = 1; dividend = 60; divisor = 6; dec_div_rem = 0;
    step;
    dec_div_valid = 0; tx_ready = 1;
    step;
    tx_ready = 0;
`ifdef EL2_DIV_NOC_TIMEOUT_EN
    for (int i = 1; i < 16; i++) step;
    chk("to_early", div_error, 0);
    chk("to_busy", div_busy, 1);
    step;
    chk("to_err", div_error, 1);
    chk("to_flush", noc_sr_flush, 1);
    chk("to_fin", finish_dly, 0);
    chk("to_idle", div_busy, 0);
    step;
    chk("to_err_pulse", div_error, 0);
`else
    for (int i = 0; i < 20; i++) step;
    chk("noto_err", div_error, 0);
    chk("noto_busy", div_busy, 1);
    rx_valid = 1; rx_packet = 10;
    step;
    rx_valid = 0;
    exp_out = 10;
    chk("noto_fin", finish_dly, 1);
    chk("noto_out", out, exp_out);
`endif
    step;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
